dcs_requant: RTL and testbench

//  Downstream stage of the DCSformer attention core. Captures each burst of N
//  32-bit accumulator results and picks one per-burst right-shift so the

---
 rtl/dcs_requant_if.sv | 36 +++
 rtl/dcs_requant.sv | 217 +++++++++++++++++++++
 tb/tb_dcs_requant.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcs_requant_if.sv
// dcs_requant_if
//  Stream bundle between the DCSformer core result port, the requantiser and
//  its downstream consumer.
//  Signals:
//   in_valid / in_data   : accumulator word strobe and value (no backpressure)
//   out_valid / out_ready: activation byte handshake
//   out_data             : requantised activation
//   out_shift            : right-shift applied to the burst being emitted
//   out_last             : marks the final byte of a burst
//   overflow             : sticky flag, a burst was dropped
//  Modports:
//   master : the side that drives words and consumes bytes (core + consumer)
//   slave  : the requantiser itself
interface dcs_requant_if #(
    parameter int IW = 32,
    parameter int OW = 8
);
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [4:0]    out_shift;
    logic          out_last;
    logic          overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_shift, out_last, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_shift, out_last, overflow
    );
endinterface

// File: rtl/dcs_requant.sv
// dcs_requant
//  Captures bursts of N unsigned accumulator words into a two-bank ping-pong
//  buffer, picks one right-shift per burst so the largest word fits in OW
//  bits, then rounds/saturates each word and streams the bytes out.
//  Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset, aborts any burst in flight
//   bus  : dcs_requant_if.slave (input words, output bytes, overflow flag)
//  N must be a power of two: the buffer address is {bank, word index}.
module dcs_requant #(
    parameter int N  = 8,
    parameter int IW = 32,
    parameter int OW = 8
) (
    input logic          clk,
    input logic          rst,
    dcs_requant_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int AW = CW + 1;

    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_state_t;
    typedef enum logic [1:0] {R_IDLE, R_CALC, R_EMIT} rd_state_t;

    // Index of the highest set bit (0 for an all-zero accumulator) mapped to
    // the shift that brings that bit down to position OW-1.
    function automatic logic [4:0] calc_shift(input logic [IW-1:0] acc);
        int m;
        m = 0;
        for (int i = 0; i < IW; i++) begin
            if (acc[i]) m = i;
        end
        return (m > OW - 1) ? 5'(m - (OW - 1)) : 5'd0;
    endfunction

    // Round-half-up right shift in IW+1 bits, then saturate to OW bits.
    function automatic logic [OW-1:0] requant(input logic [IW-1:0] w, input logic [4:0] s);
        logic [IW:0] r;
        if (s == 5'd0) begin
            r = {1'b0, w};
        end else begin
            r = ({1'b0, w} + ((IW+1)'(1) << (s - 5'd1))) >> s;
        end
        if (r > {{(IW+1-OW){1'b0}}, {OW{1'b1}}}) begin
            return {OW{1'b1}};
        end
        return r[OW-1:0];
    endfunction

    // Bank bookkeeping
    bank_state_t   bank_state_reg [2];
    logic [IW-1:0] acc_reg [2];
    logic [4:0]    shift_reg [2];

    // Burst buffer, both banks in one array
    logic [IW-1:0] mem [2*N];

    // Write side
    logic          wp_reg;
    logic [CW-1:0] wcnt_reg;
    logic          drop_reg;
    logic          overflow_reg;
    logic          wr_first, wr_last, wr_bank_empty, wr_accept, wr_drop_start;

    // Read side
    rd_state_t     rd_state_reg, rd_state_next;
    logic          rp_reg;
    logic [CW-1:0] rd_addr_reg;
    logic [CW-1:0] ocnt_reg;
    logic [IW-1:0] rd_word_reg;
    logic          out_valid_reg;
    logic [OW-1:0] out_data_reg;
    logic [4:0]    out_shift_reg;
    logic          out_last_reg;
    logic          hs, rd_start, rd_en, load_first, advance, finish;

    // ---------------- write side ----------------
    assign wr_first      = (wcnt_reg == '0);
    assign wr_last       = (wcnt_reg == CW'(N - 1));
    assign wr_bank_empty = (bank_state_reg[wp_reg] == B_EMPTY);
    // The first word decides the fate of the whole burst; later words follow it.
    assign wr_accept     = bus.in_valid && (wr_first ? wr_bank_empty : !drop_reg);
    assign wr_drop_start = bus.in_valid && wr_first && !wr_bank_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_reg       <= 1'b0;
            wcnt_reg     <= '0;
            drop_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (bus.in_valid) begin
            wcnt_reg <= wr_last ? '0 : wcnt_reg + CW'(1);
            if (wr_last) begin
                drop_reg <= 1'b0;
            end else if (wr_first) begin
                drop_reg <= !wr_bank_empty;
            end
            if (wr_drop_start) overflow_reg <= 1'b1;
            if (wr_accept && wr_last) wp_reg <= ~wp_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[{wp_reg, wcnt_reg}] <= bus.in_data;
    end

    // Registered read port; word k+1 is prefetched while byte k is on the bus.
    always_ff @(posedge clk) begin
        if (rd_en) rd_word_reg <= mem[{rp_reg, rd_addr_reg}];
    end

    // ---------------- per-bank state ----------------
    // Writer only touches EMPTY/FILL banks, reader only FULL/DRAIN banks,
    // so the two sides never update the same bank in one cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (rst) begin
                    bank_state_reg[gi] <= B_EMPTY;
                    acc_reg[gi]        <= '0;
                    shift_reg[gi]      <= 5'd0;
                end else begin
                    if (wr_accept && wp_reg == 1'(gi)) begin
                        acc_reg[gi]        <= wr_first ? bus.in_data : (acc_reg[gi] | bus.in_data);
                        bank_state_reg[gi] <= wr_last ? B_FULL : B_FILL;
                    end
                    if (rd_start && rp_reg == 1'(gi)) bank_state_reg[gi] <= B_DRAIN;
                    if (finish && rp_reg == 1'(gi))   bank_state_reg[gi] <= B_EMPTY;
                    // The accumulator is final once FULL, so the shift is ready
                    // one cycle later, in time for the R_CALC -> R_EMIT load.
                    if (bank_state_reg[gi] == B_FULL) shift_reg[gi] <= calc_shift(acc_reg[gi]);
                end
            end
        end
    endgenerate

    // ---------------- read FSM ----------------
    assign hs = out_valid_reg && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) rd_state_reg <= R_IDLE;
        else     rd_state_reg <= rd_state_next;
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rd_start      = 1'b0;
        rd_en         = 1'b0;
        load_first    = 1'b0;
        advance       = 1'b0;
        finish        = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                if (bank_state_reg[rp_reg] == B_FULL) begin
                    rd_state_next = R_CALC;
                    rd_start      = 1'b1;
                    rd_en         = 1'b1;
                end
            end
            R_CALC: begin
                rd_state_next = R_EMIT;
                load_first    = 1'b1;
                rd_en         = 1'b1;
            end
            R_EMIT: begin
                if (hs) begin
                    if (ocnt_reg == CW'(N - 1)) begin
                        rd_state_next = R_IDLE;
                        finish        = 1'b1;
                    end else begin
                        advance = 1'b1;
                        rd_en   = 1'b1;
                    end
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_reg        <= 1'b0;
            rd_addr_reg   <= '0;
            ocnt_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_shift_reg <= 5'd0;
            out_last_reg  <= 1'b0;
        end else begin
            if (rd_en) rd_addr_reg <= rd_addr_reg + CW'(1);
            if (load_first) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= requant(rd_word_reg, shift_reg[rp_reg]);
                out_shift_reg <= shift_reg[rp_reg];
                out_last_reg  <= 1'b0;
                ocnt_reg      <= '0;
            end
            if (advance) begin
                out_data_reg <= requant(rd_word_reg, out_shift_reg);
                ocnt_reg     <= ocnt_reg + CW'(1);
                out_last_reg <= (ocnt_reg == CW'(N - 2));
            end
            if (finish) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                rp_reg        <= ~rp_reg;
                rd_addr_reg   <= '0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_shift = out_shift_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_dcs_requant.sv
// tb_dcs_requant
//  Table of bursts with hand-computed shifts and bytes, fed through a
//  scoreboard queue and checked at the output handshake, plus directed
//  sequences for latency, stalls, back-to-back bursts, drops and reset.
module tb_dcs_requant;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcs_requant_if #(.IW(32), .OW(8)) bus ();

    dcs_requant #(.N(8), .IW(32), .OW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0][31:0] words;
        logic [4:0]       shift;
        logic [7:0][7:0]  bytes;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] shift;
        logic       last;
    } exp_t;

    vec_t vecs [6];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    logic stall_prev = 1'b0;
    exp_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Output monitor: samples on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_data", 32'(bus.out_data), 32'(held.data));
                    chk("hold_shift", 32'(bus.out_shift), 32'(held.shift));
                    chk("hold_last", 32'(bus.out_last), 32'(held.last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got byte %0d, required no output", bus.out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e.data));
                        chk("out_shift", 32'(bus.out_shift), 32'(e.shift));
                        chk("out_last", 32'(bus.out_last), 32'(e.last));
                        pops++;
                        $display("out byte=%0d shift=%0d last=%0d (expected %0d/%0d/%0d)",
                                 bus.out_data, bus.out_shift, bus.out_last, e.data, e.shift, e.last);
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held = {bus.out_data, bus.out_shift, bus.out_last};
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic send_burst(input int v, input int gap, input bit keep);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (keep) begin
                e.data  = vecs[v].bytes[i];
                e.shift = vecs[v].shift;
                e.last  = (i == 7);
                sb.push_back(e);
            end
            send_word(vecs[v].words[i]);
            if (gap > 0 && i < 7) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int target;
        int n;

        for (int v = 0; v < 6; v++) begin
            vecs[v].words = '0;
            vecs[v].bytes = '0;
            vecs[v].shift = 5'd0;
        end
        for (int i = 0; i < 8; i++) begin
            vecs[0].words[i] = 32'(10 * (i + 1));
            vecs[0].bytes[i] = 8'(10 * (i + 1));
            vecs[3].words[i] = 32'h100;
            vecs[3].bytes[i] = 8'd128;
        end
        vecs[1].words[0] = 32'h0001_2345; vecs[1].bytes[0] = 8'd146;
        vecs[1].words[1] = 32'h0001_FF00; vecs[1].bytes[1] = 8'd255;
        vecs[1].shift    = 5'd9;
        vecs[3].shift    = 5'd1;
        vecs[4].words[0] = 32'd512; vecs[4].bytes[0] = 8'd128;
        vecs[4].words[1] = 32'd3;   vecs[4].bytes[1] = 8'd1;
        vecs[4].words[2] = 32'd1;   vecs[4].bytes[2] = 8'd0;
        vecs[4].words[3] = 32'd511; vecs[4].bytes[3] = 8'd128;
        vecs[4].words[4] = 32'd6;   vecs[4].bytes[4] = 8'd2;
        vecs[4].shift    = 5'd2;
        vecs[5].words[0] = 32'hFFFF_FFFF; vecs[5].bytes[0] = 8'd255;
        vecs[5].words[1] = 32'h8000_0000; vecs[5].bytes[1] = 8'd128;
        vecs[5].words[2] = 32'h0080_0000; vecs[5].bytes[2] = 8'd1;
        vecs[5].words[3] = 32'h007F_FFFF; vecs[5].bytes[3] = 8'd0;
        vecs[5].shift    = 5'd24;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_shift", 32'(bus.out_shift), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;

        // Latency: last word sampled at T, out_valid first high after T+2
        send_burst(0, 0, 1'b1);
        @(negedge clk);
        chk("lat_T0_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_T1_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_T2_valid", 32'(bus.out_valid), 32'd1);
        wait_drain();

        // Table-driven bursts, odd entries with gaps in in_valid
        for (int v = 1; v < 6; v++) begin
            @(posedge clk);
            #1;
            send_burst(v, v % 2, 1'b1);
            wait_drain();
        end

        // Back-to-back bursts with a 3-cycle consumer stall mid-emission
        @(posedge clk);
        #1;
        send_burst(4, 0, 1'b1);
        fork
            send_burst(5, 0, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("b2b_overflow", 32'(bus.overflow), 32'd0);

        // Both banks busy: third burst dropped, overflow sticks
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send_burst(0, 0, 1'b1);
        send_burst(1, 0, 1'b1);
        send_burst(2, 0, 1'b0);
        @(negedge clk);
        chk("drop_overflow", 32'(bus.overflow), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;
        send_burst(3, 0, 1'b1);
        wait_drain();
        chk("sticky_overflow", 32'(bus.overflow), 32'd1);

        // Reset while byte 4 of a burst is on the bus
        @(posedge clk);
        #1;
        target = pops + 4;
        send_burst(0, 0, 1'b1);
        n = 0;
        while (pops < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("pre_rst_pops", 32'(pops), 32'(target));
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("post_rst_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1;
        send_burst(3, 0, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
